// File: rtl/adc_stim_sched_if.sv
// AXI-Stream style output bundle of the ADC stimulus scheduler.
// The master drives data/valid/last, and the slave returns ready.
interface adc_stim_sched_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/adc_stim_sched.sv
// ADC sample scheduler: a FWFT FIFO drained in bursts of burst_len beats
// separated by gap_len idle cycles, with start/stop control and traffic stats.
module adc_stim_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_val,
  input  logic                          start,
  input  logic                          stop,
  input  logic [CNT_WIDTH-1:0]          burst_len,
  input  logic [CNT_WIDTH-1:0]          gap_len,
  adc_stim_sched_if.master              m,
  output logic                          busy,
  output logic                          overflow,
  output logic [15:0]                   underrun_cnt,
  output logic [31:0]                   beat_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    GAP
  } state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           level;
  logic [CNT_WIDTH-1:0]  blen_q, glen_q;
  logic [CNT_WIDTH-1:0]  bcnt, gcnt;
  logic                  stop_pend, stop_any;
  logic                  full, empty;
  logic                  push, pop, drop;
  logic                  go, last, gap_end;

  assign full     = (level == DEPTH);
  assign empty    = (level == '0);
  assign pop      = m.tvalid & m.tready;
  assign push     = in_val & (~full | pop);
  assign drop     = in_val & full & ~pop;
  assign go       = (state == IDLE) & start & ~stop;
  assign stop_any = stop_pend | stop;
  assign last     = (bcnt == blen_q - ONE);
  assign gap_end  = (gcnt == glen_q - ONE);

  assign m.tdata    = mem[rd_ptr];
  assign busy       = (state != IDLE);
  assign fifo_level = level;

  always_comb begin
    state_nx = state;
    m.tvalid = 1'b0;
    m.tlast  = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) state_nx = BURST;
      end
      BURST: begin
        m.tvalid = ~empty;
        m.tlast  = ~empty & last;
        // A burst only ends on its last handshake, never mid-burst
        if (pop && last) begin
          if (stop_any)          state_nx = IDLE;
          else if (glen_q != '0) state_nx = GAP;
          else                   state_nx = BURST;
        end
      end
      GAP: begin
        if (gap_end) state_nx = stop_any ? IDLE : BURST;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      blen_q    <= ONE;
      glen_q    <= '0;
      bcnt      <= '0;
      gcnt      <= '0;
      stop_pend <= 1'b0;
    end else begin
      state <= state_nx;
      if (go) begin
        blen_q <= (burst_len == '0) ? ONE : burst_len;
        glen_q <= gap_len;
      end
      if (go)       bcnt <= '0;
      else if (pop) bcnt <= last ? '0 : bcnt + ONE;
      gcnt <= (state == GAP) ? gcnt + ONE : '0;
      if (state_nx == IDLE) stop_pend <= 1'b0;
      else if (stop)        stop_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow     <= 1'b0;
      underrun_cnt <= '0;
      beat_cnt     <= '0;
    end else begin
      // A drop in the start cycle still counts against the new run
      if (drop)    overflow <= 1'b1;
      else if (go) overflow <= 1'b0;
      if (go)
        underrun_cnt <= '0;
      else if (state == BURST && empty && underrun_cnt != 16'hFFFF)
        underrun_cnt <= underrun_cnt + 16'd1;
      if (go)       beat_cnt <= '0;
      else if (pop) beat_cnt <= beat_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_adc_stim_sched.sv
// Self-checking bench for adc_stim_sched against a queue-based traffic model.
// Directed phases plus a randomized phase, checked every cycle.
module tb_adc_stim_sched;

  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_val, start, stop;
  logic [CW-1:0] burst_len, gap_len;
  logic          busy, overflow;
  logic [15:0]   underrun_cnt;
  logic [31:0]   beat_cnt;
  logic [6:0]    fifo_level;

  adc_stim_sched_if #(.DATA_WIDTH(DW)) axis ();

  adc_stim_sched #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_val      (in_val),
    .start       (start),
    .stop        (stop),
    .burst_len   (burst_len),
    .gap_len     (gap_len),
    .m           (axis),
    .busy        (busy),
    .overflow    (overflow),
    .underrun_cnt(underrun_cnt),
    .beat_cnt    (beat_cnt),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: traffic described by a sample queue and burst progress
  logic [DW-1:0] q[$];
  bit            active;
  int            gap_left;
  int            bdone;
  int            mblen, mglen;
  bit            stop_p;
  bit            m_ovf;
  int            m_und;
  logic [31:0]   m_beats;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_valid();
    return active && gap_left == 0 && q.size() > 0;
  endfunction

  task automatic model_reset();
    q.delete();
    active   = 0;
    gap_left = 0;
    bdone    = 0;
    mblen    = 1;
    mglen    = 0;
    stop_p   = 0;
    m_ovf    = 0;
    m_und    = 0;
    m_beats  = 0;
  endtask

  task automatic check_outputs();
    bit ev, el;
    ev = exp_valid();
    el = ev && (bdone == mblen - 1);
    chk("busy",     64'(busy),         64'(active));
    chk("tvalid",   64'(axis.tvalid),  64'(ev));
    chk("tlast",    64'(axis.tlast),   64'(el));
    chk("level",    64'(fifo_level),   64'(q.size()));
    chk("overflow", 64'(overflow),     64'(m_ovf));
    chk("underrun", 64'(underrun_cnt), 64'(m_und));
    chk("beats",    64'(beat_cnt),     64'(m_beats));
    if (ev) chk("tdata", 64'(axis.tdata), 64'(q[0]));
  endtask

  task automatic model_update(bit v, logic [DW-1:0] d, bit s, bit sp,
                              bit r, int bl, int gl);
    bit ev, pop, was;
    int sz;
    ev  = exp_valid();
    pop = ev && r;
    sz  = q.size();
    was = active;
    if (!active) begin
      if (s && !sp) begin
        active   = 1;
        mblen    = (bl == 0) ? 1 : bl;
        mglen    = gl;
        bdone    = 0;
        gap_left = 0;
        m_ovf    = 0;
        m_und    = 0;
        m_beats  = 0;
      end
    end else if (gap_left > 0) begin
      if (gap_left == 1 && (stop_p || sp)) active = 0;
      gap_left--;
    end else begin
      if (sz == 0 && m_und < 65535) m_und++;
      if (pop) begin
        m_beats++;
        bdone++;
        if (bdone == mblen) begin
          bdone = 0;
          if (stop_p || sp) active = 0;
          else gap_left = mglen;
        end
      end
    end
    if (was && !active) stop_p = 0;
    else if (was && sp) stop_p = 1;
    if (pop) void'(q.pop_front());
    if (v) begin
      if (sz < DEPTH || pop) q.push_back(d);
      else m_ovf = 1;
    end
  endtask

  task automatic step(bit v, logic [DW-1:0] d, bit s, bit sp,
                      bit r, int bl, int gl);
    @(negedge clk);
    in_val      = v;
    in_data     = d;
    start       = s;
    stop        = sp;
    axis.tready = r;
    burst_len   = CW'(bl);
    gap_len     = CW'(gl);
    #1;
    check_outputs();
    model_update(v, d, s, sp, r, bl, gl);
  endtask

  task automatic idle_inputs();
    in_val      = 0;
    in_data     = '0;
    start       = 0;
    stop        = 0;
    axis.tready = 0;
    burst_len   = '0;
    gap_len     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    idle_inputs();
    rst_n = 0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic sample_now();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int n;
    idle_inputs();
    model_reset();
    rst_n = 0;
    #3;
    check_outputs();
    @(negedge clk);
    rst_n = 1;

    // Prefill then stream
    for (int i = 1; i <= 16; i++) step(1, DW'(i), 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1, 4, 3);
    n = 0;
    while (m_beats != 16 && n < 80) begin
      step(0, 0, 0, 0, 1, 0, 0);
      n++;
    end
    chk("stream_tmo", 64'(m_beats == 16), 64'd1);
    sample_now();
    chk("stream_beats", 64'(beat_cnt), 64'd16);
    chk("stream_und", 64'(underrun_cnt), 64'd0);

    // Backpressure
    do_reset();
    for (int i = 0; i < 12; i++) step(1, DW'($urandom), 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 4, 1);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 0, bit'(i % 2), 0, 0);

    // Overflow, then push+pop at full
    do_reset();
    for (int i = 1; i <= 70; i++) step(1, DW'(i), 0, 0, 0, 0, 0);
    sample_now();
    chk("ovf_level", 64'(fifo_level), 64'd64);
    chk("ovf_flag", 64'(overflow), 64'd1);
    step(0, 0, 1, 0, 0, 100, 0);
    for (int i = 0; i < 20; i++) step(1, DW'($urandom), 0, 0, 1, 0, 0);
    sample_now();
    chk("full_pp_level", 64'(fifo_level), 64'd64);

    // Underrun
    do_reset();
    step(0, 0, 1, 0, 1, 8, 0);
    for (int i = 1; i <= 30; i++)
      step(bit'(i % 3 == 0), DW'($urandom), 0, 0, 1, 0, 0);

    // Stop mid-burst, then start+stop in IDLE
    do_reset();
    for (int i = 0; i < 8; i++) step(1, DW'($urandom), 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 8, 2);
    n = 0;
    while (m_beats != 3 && n < 20) begin
      step(0, 0, 0, 0, 1, 0, 0);
      n++;
    end
    chk("stop_tmo3", 64'(m_beats == 3), 64'd1);
    step(0, 0, 0, 1, 1, 0, 0);
    n = 0;
    while (active && n < 30) begin
      step(0, 0, 0, 0, 1, 0, 0);
      n++;
    end
    chk("stop_tmo_idle", 64'(active), 64'd0);
    sample_now();
    chk("stop_busy", 64'(busy), 64'd0);
    chk("stop_beats", 64'(beat_cnt), 64'd8);
    step(0, 0, 1, 1, 1, 4, 0);
    sample_now();
    chk("startstop_busy", 64'(busy), 64'd0);

    // Zero lengths
    do_reset();
    for (int i = 0; i < 6; i++) step(1, DW'($urandom), 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 0, 0);

    // Async reset mid-burst
    do_reset();
    for (int i = 0; i < 6; i++) step(1, DW'($urandom), 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 8, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0);
    chk("pre_rst_valid", 64'(axis.tvalid), 64'd1);
    do_reset();
    chk("rst_level", 64'(fifo_level), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(1, 0)), DW'($urandom),
           bit'($urandom_range(7, 0) == 0), bit'($urandom_range(15, 0) == 0),
           bit'($urandom_range(3, 0) != 0),
           int'($urandom_range(5, 0)), int'($urandom_range(3, 0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_stim_sched.md
Name: adc_stim_sched

Overview:
- Scheduling controller between a free-running sample source (ADC stimulus reader or ADC front end: data + valid, no backpressure) and a downstream AXI-Stream consumer.
- Buffers samples in an internal FIFO and releases them in bursts of `burst_len` beats separated by `gap_len` idle cycles, under start/stop control.
- Reports overflow, underrun and beat statistics so benches and firmware can verify the traffic.

Parameters:
- DATA_WIDTH, 16, sample width in bits.
- FIFO_DEPTH, 64, FIFO entries; power of 2, ≥ 4.
- CNT_WIDTH, 16, width of `burst_len` and `gap_len`.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_data  in  DATA_WIDTH  source sample, signed.
- in_val  in  1  source sample valid; no backpressure to the source.
- start  in  1  single-cycle start pulse.
- stop  in  1  single-cycle stop request pulse.
- burst_len  in  CNT_WIDTH  beats per burst, sampled on start; 0 is treated as 1.
- gap_len  in  CNT_WIDTH  idle cycles between bursts, sampled on start; 0 means back-to-back bursts.
- m_tdata  out  DATA_WIDTH  output sample.
- m_tvalid  out  1  output valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  high on the final beat of each burst.
- busy  out  1  high when state ≠ IDLE.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- underrun_cnt  out  16  cycles spent in BURST with the FIFO empty; saturates at 0xFFFF.
- beat_cnt  out  32  handshaked beats since the last start; wraps.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, `rst_n` = 0):
  - state = IDLE; FIFO emptied.
  - `m_tvalid`, `m_tlast`, `busy`, `overflow` = 0.
  - `underrun_cnt`, `beat_cnt`, `fifo_level` = 0.
  - Reset mid-burst discards any pending beat with no completion.
- FIFO:
  - First-word-fall-through; write and read in every state, so the FIFO prefills in IDLE.
  - Push when `in_val` = 1 and (level < FIFO_DEPTH or a pop occurs in the same cycle).
  - If `in_val` = 1 at full with no pop, drop the sample and set `overflow`.
  - A sample pushed in cycle N is visible on `m_tdata` in cycle N+1.
  - Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop leaves the level unchanged.
- Pop: occurs on `m_tvalid` & `m_tready` (a handshake).
- States:
  - IDLE:
    - `m_tvalid` = 0.
    - On `start` (with `stop` = 0): latch `burst_len` and `gap_len`; clear `bcnt`, `overflow`, `underrun_cnt`, `beat_cnt`; go to BURST.
    - `start` and `stop` together in IDLE: stop wins, remain IDLE.
  - BURST:
    - `m_tvalid` = (level ≠ 0).
    - `m_tlast` = `m_tvalid` & (`bcnt` == eff_len−1), where eff_len = max(`burst_len`, 1).
    - On handshake: `bcnt`++ and `beat_cnt`++.
    - On the handshake with `m_tlast`:
      - `bcnt` = 0.
      - If `stop_pend`, go to IDLE.
      - Otherwise, if gap > 0, go to GAP; else stay in BURST.
    - Empty FIFO in BURST: `underrun_cnt`++ (saturating).
  - GAP:
    - `m_tvalid` = 0; counts `gap_len` cycles.
    - When `gcnt` == `gap_len`−1: go to IDLE if `stop_pend`, else to BURST.
- Stop handling:
  - `stop` outside IDLE sets `stop_pend`. The current burst always completes, so AXI rules are never violated mid-burst.
  - `stop_pend` is cleared on entry to IDLE.
- `start` outside IDLE is ignored.
- AXI-Stream rules:
  - Once `m_tvalid` is high it stays high, with `m_tdata`/`m_tlast` stable, until the handshake. The FIFO cannot become empty without a pop, and the state cannot leave BURST without the last handshake.
  - `m_tdata` is undefined while `m_tvalid` = 0.
- Counters:
  - `bcnt` and `gcnt` are CNT_WIDTH bits.
  - Run-time `burst_len`/`gap_len` changes take effect only at the next start.

Test Plan:
- Prefill then stream: reset; push 16 samples 0x0001..0x0010 in IDLE; start with `burst_len`=4, `gap_len`=3, `m_tready`=1.
  - Required: beats 1–4 on 4 consecutive cycles with `m_tlast` on 0x0004; then 3 idle cycles; then 0x0005..0x0008.
  - After 4 bursts: `beat_cnt`=16, `underrun_cnt`=0.
- Backpressure: toggle `m_tready` 1/0 during bursts.
  - Required: `m_tvalid`, `m_tdata` and `m_tlast` held stable while `m_tready`=0; output order unchanged; no lost beats.
- Overflow: FIFO_DEPTH=64, hold `m_tready`=0, push 70 samples.
  - Required: `fifo_level`=64, `overflow`=1, first 64 samples retained, samples 65–70 dropped.
  - Push and pop in the same cycle at full: level stays 64 and `overflow` stays unchanged.
- Underrun: start with an empty FIFO and `burst_len`=8, feed 1 sample every 3 cycles.
  - Required: `m_tvalid` pulses once per sample and `underrun_cnt` increments on empty cycles.
  - `m_tlast` on the 8th beat only.
- Stop mid-burst: `burst_len`=8, assert `stop` after beat 3.
  - Required: beats 4–8 still delivered, `m_tlast` on beat 8, then IDLE and `busy`=0.
  - A `start`+`stop` pulse in IDLE leaves `busy`=0.
- Edge lengths: `burst_len`=0 with `gap_len`=0.
  - Required: every beat has `m_tlast`=1 and beats are back-to-back.
- Async reset mid-burst: reset during a burst.
  - Required: all outputs 0 immediately without waiting for a clock, and `fifo_level`=0.
